pico_exec_core: RTL and testbench
=================================

// Module: pico_exec_core
// PURPOSE
//   Parametrised successor of the pin-fed 8-bit execution core: one 16-bit instruction per
//   valid/ready transfer, executed by a small FSM against an NREGS x XLEN register file
//   and a DMEM_DEPTH-word data memory. Each instruction yields one result beat on a
//   valid/ready result channel. Sits between the host instruction feeder and the pin/debug
//   output mux. Branches resolve within their own instruction; adds load/store.
// PARAMETERS
//   XLEN        8   data/register width, 8..32
//   PC_W        8   program-counter width; PC wraps modulo 2**PC_W
//   DMEM_AW     4   data-memory address bits; DMEM_DEPTH = 2**DMEM_AW words of XLEN
//   SIGNED_CMP  0   1: SLT/SLTI/BLT/BGE compare signed; 0: unsigned
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   instr_valid  in   1       instruction offered
//   instr_ready  out  1       core accepts instruction (high only in IDLE)
//   instr        in   16      op[1:0] rd[4:2] rs1[7:5] rs2[10:8] imm5[12:8] f3[15:13]
//   res_valid    out  1       result beat valid; held until res_ready
//   res_ready    in   1       consumer accepts result
//   res_data     out  XLEN    value written to rd / store data / 0 for branch
//   res_rd       out  3       destination register of the retired instruction
//   res_pc       out  PC_W    PC of the retired instruction
//   res_taken    out  1       branch taken (0 for non-branch)
//   dbg_sel      in   3       debug register select
//   dbg_data     out  XLEN    combinational x[dbg_sel]
// BEHAVIOUR
//   Reset (async, rst_n=0): x1..x7=0, dmem all 0, pc=0, state=IDLE, instr_ready=1,
//     res_valid=0, res_data=0, res_rd=0, res_pc=0, res_taken=0. Mid-op reset aborts;
//     no partial register or memory write survives.
//   FSM: IDLE -(instr_valid)-> EXEC -> RESP, or EXEC -> MEM -> RESP for LOAD;
//     RESP -(res_ready)-> IDLE. instr latched on the accept edge; instr_ready=(state==IDLE).
//   Latency: res_valid rises 2 edges after accept (3 for LOAD). Min 3 cycles/instr.
//   x0 reads 0 always; writes to rd=0 dropped; res_data still reports the computed value.
//   op 00 R-type, b=x[rs2]: f3 000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLL,110 SRL,
//     111 SLT (result 1/0). Shift amount = b[$clog2(XLEN)-1:0]. ADD/SUB wrap mod 2**XLEN.
//   op 01 I-type, imm=zero-extended imm5: f3 000 ADDI,010 SLTI,011 ANDI,100 ORI,
//     110 XORI, all others LI (rd<=imm).
//   op 10 memory, addr=(x[rs1]+imm5) mod DMEM_DEPTH: f3 000 LOAD rd<=dmem[addr]
//     (written on MEM edge); f3 001 STORE dmem[addr]<=x[rd]; other f3 = NOP, rd unchanged.
//   op 11 branch: compare x[rd] vs x[rs1]; f3[1:0] 00 EQ,01 NE,10 LT,11 GE.
//     Taken: pc<=pc+sext(imm5); else pc<=pc+1. Decision uses this instruction's operands.
//   All non-branch ops: pc<=pc+1 on commit edge. res_pc = pc before update.
//   Result outputs registered, stable while res_valid=1 and res_ready=0.
//   Register values read at EXEC see all prior commits (no hazards: one instr in flight).
//   instr_valid in non-IDLE states ignored; instr may change freely when instr_ready=0.
// TESTING
//   Reset, then LI x1,5 (f3=111) -> res_valid 2 cycles after accept, res_data=5, res_rd=1,
//     res_pc=0; dbg_sel=1 -> dbg_data=5.
//   x1=5,x2=7: SUB x3,x1,x2 -> res_data=8'hFE; SLT x4,x1,x2 -> 1; SLL x5,x2,x1 -> 8'hE0.
//   STORE x1 to addr x0+3, then LOAD x6 from addr 3 -> x6=5, LOAD res_valid 3 cycles
//     after accept; addr x1+imm 14 with x1=5 wraps to 3 (DMEM_AW=4).
//   BEQ x1,x1,imm5=-2 at pc=10 -> res_taken=1, next res_pc=8; BNE x1,x1 -> pc=11.
//   Hold res_ready=0 5 cycles -> res_* stable, instr_ready=0, offered instr not accepted;
//     ADD to rd=0 -> x0 stays 0.
//   Assert rst_n low in MEM of a LOAD -> target reg unchanged (0), all outputs at reset values.

Source files
------------

// File: rtl/pico_exec_core.sv
// Multi-cycle 16-bit instruction execution core: IDLE/EXEC/MEM/RESP FSM over an
// NREGS x XLEN register file and a small data memory, one result beat per instruction.
module pico_exec_core #(
  parameter int unsigned XLEN       = 8,
  parameter int unsigned PC_W       = 8,
  parameter int unsigned DMEM_AW    = 4,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [2:0]      res_rd,
  output logic [PC_W-1:0] res_pc,
  output logic            res_taken,
  input  logic [2:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned DEPTH = 2 ** DMEM_AW;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [XLEN-1:0]     rf_q   [8];
  logic [XLEN-1:0]     rf_d   [8];
  logic [XLEN-1:0]     dmem_q [DEPTH];
  logic [XLEN-1:0]     dmem_d [DEPTH];
  logic [XLEN-1:0]     res_data_q, res_data_d;
  logic [2:0]          res_rd_q, res_rd_d;
  logic [PC_W-1:0]     res_pc_q, res_pc_d;
  logic                res_taken_q, res_taken_d;

  logic [1:0]          op;
  logic [2:0]          rd, rs1, rs2, f3;
  logic [4:0]          imm5;
  logic [XLEN-1:0]     xs1, xs2, xrd, imm_x, alu_res;
  logic [PC_W-1:0]     br_off;
  logic [DMEM_AW-1:0]  mem_addr;
  logic                alu_wr, is_load, is_store, taken;

  function automatic logic lt_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (SIGNED_CMP) return $signed(a) < $signed(b);
    else            return a < b;
  endfunction

  // Operand fetch and decode from the latched instruction
  always_comb begin
    op       = ir_q[1:0];
    rd       = ir_q[4:2];
    rs1      = ir_q[7:5];
    rs2      = ir_q[10:8];
    imm5     = ir_q[12:8];
    f3       = ir_q[15:13];
    xs1      = (rs1 == 3'd0) ? '0 : rf_q[rs1];
    xs2      = (rs2 == 3'd0) ? '0 : rf_q[rs2];
    xrd      = (rd  == 3'd0) ? '0 : rf_q[rd];
    imm_x    = {{(XLEN-5){1'b0}}, imm5};
    br_off   = {{(PC_W-5){imm5[4]}}, imm5};
    mem_addr = DMEM_AW'(xs1) + DMEM_AW'(imm_x);
  end

  always_comb begin
    alu_res  = '0;
    alu_wr   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    taken    = 1'b0;
    case (op)
      2'b00: begin
        alu_wr = 1'b1;
        case (f3)
          3'b000:  alu_res = xs1 + xs2;
          3'b001:  alu_res = xs1 - xs2;
          3'b010:  alu_res = xs1 & xs2;
          3'b011:  alu_res = xs1 | xs2;
          3'b100:  alu_res = xs1 ^ xs2;
          3'b101:  alu_res = xs1 << xs2[SHW-1:0];
          3'b110:  alu_res = xs1 >> xs2[SHW-1:0];
          default: alu_res = XLEN'(lt_f(xs1, xs2));
        endcase
      end
      2'b01: begin
        alu_wr = 1'b1;
        case (f3)
          3'b000:  alu_res = xs1 + imm_x;
          3'b010:  alu_res = XLEN'(lt_f(xs1, imm_x));
          3'b011:  alu_res = xs1 & imm_x;
          3'b100:  alu_res = xs1 | imm_x;
          3'b110:  alu_res = xs1 ^ imm_x;
          default: alu_res = imm_x;
        endcase
      end
      2'b10: begin
        if (f3 == 3'b000) begin
          is_load = 1'b1;
        end else if (f3 == 3'b001) begin
          is_store = 1'b1;
          alu_res  = xrd;
        end
      end
      default: begin
        case (f3[1:0])
          2'b00:   taken = (xrd == xs1);
          2'b01:   taken = (xrd != xs1);
          2'b10:   taken = lt_f(xrd, xs1);
          default: taken = !lt_f(xrd, xs1);
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_EXEC;
      S_EXEC:  state_d = is_load ? S_MEM : S_RESP;
      S_MEM:   state_d = S_RESP;
      S_RESP:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == S_IDLE);
    res_valid   = (state_q == S_RESP);
    res_data    = res_data_q;
    res_rd      = res_rd_q;
    res_pc      = res_pc_q;
    res_taken   = res_taken_q;
    dbg_data    = (dbg_sel == 3'd0) ? '0 : rf_q[dbg_sel];
  end

  // Commit happens on the EXEC edge, except loads which commit on the MEM edge
  always_comb begin
    ir_d        = ir_q;
    pc_d        = pc_q;
    rf_d        = rf_q;
    dmem_d      = dmem_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_pc_d    = res_pc_q;
    res_taken_d = res_taken_q;
    if (state_q == S_IDLE && instr_valid) ir_d = instr;
    if (state_q == S_EXEC && !is_load) begin
      pc_d        = taken ? pc_q + br_off : pc_q + PC_W'(1);
      res_data_d  = alu_res;
      res_rd_d    = rd;
      res_pc_d    = pc_q;
      res_taken_d = taken;
      if (alu_wr && rd != 3'd0) rf_d[rd] = alu_res;
      if (is_store) dmem_d[mem_addr] = xrd;
    end
    if (state_q == S_MEM) begin
      pc_d        = pc_q + PC_W'(1);
      res_data_d  = dmem_q[mem_addr];
      res_rd_d    = rd;
      res_pc_d    = pc_q;
      res_taken_d = 1'b0;
      if (rd != 3'd0) rf_d[rd] = dmem_q[mem_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q        <= '0;
      pc_q        <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_pc_q    <= '0;
      res_taken_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++)     rf_q[i]   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_pc_q    <= res_pc_d;
      res_taken_q <= res_taken_d;
      rf_q        <= rf_d;
      dmem_q      <= dmem_d;
    end
  end

endmodule

// File: tb/tb_pico_exec_core.sv
// Directed + randomized bench for pico_exec_core with an instruction-level reference model.
module tb_pico_exec_core;

  localparam int XLEN = 8;
  localparam int MASK = 255;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [15:0]     instr;
  logic            res_valid;
  logic            res_ready;
  logic [7:0]      res_data;
  logic [2:0]      res_rd;
  logic [7:0]      res_pc;
  logic            res_taken;
  logic [2:0]      dbg_sel;
  logic [7:0]      dbg_data;

  int vectors = 0;
  int errors  = 0;
  int mx [8];
  int mm [DEPTH];
  int mpc;
  int obs_data, obs_pc, obs_taken;

  pico_exec_core #(.XLEN(8), .PC_W(8), .DMEM_AW(4), .SIGNED_CMP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_pc(res_pc), .res_taken(res_taken), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [1:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [4:0] imm,
                                      input logic [2:0] f3);
    return {f3, imm, rs1, rd, op};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mx[i] = 0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 0;
    mpc = 0;
  endfunction

  // Architectural effect of one instruction, straight from the ISA rules
  function automatic void model(input logic [15:0] ins, output int d, output int rdo,
                                output int pcv, output int tk, output int lat);
    int op, rd, rs1, rs2, imm, f3, a, b, sh, addr, wr, simm;
    op = int'(ins[1:0]);  rd = int'(ins[4:2]);   rs1 = int'(ins[7:5]);
    rs2 = int'(ins[10:8]); imm = int'(ins[12:8]); f3 = int'(ins[15:13]);
    a = mx[rs1]; b = mx[rs2]; sh = b % XLEN;
    d = 0; tk = 0; lat = 2; wr = 0;
    case (op)
      0: begin
        wr = 1;
        case (f3)
          0: d = (a + b) & MASK;
          1: d = (a - b) & MASK;
          2: d = a & b;
          3: d = a | b;
          4: d = a ^ b;
          5: d = (a << sh) & MASK;
          6: d = a >> sh;
          default: d = (a < b) ? 1 : 0;
        endcase
      end
      1: begin
        wr = 1;
        case (f3)
          0: d = (a + imm) & MASK;
          2: d = (a < imm) ? 1 : 0;
          3: d = a & imm;
          4: d = a | imm;
          6: d = a ^ imm;
          default: d = imm;
        endcase
      end
      2: begin
        addr = (a + imm) % DEPTH;
        if (f3 == 0) begin d = mm[addr]; wr = 1; lat = 3; end
        else if (f3 == 1) begin mm[addr] = mx[rd]; d = mx[rd]; end
      end
      default: begin
        case (f3 % 4)
          0: tk = (mx[rd] == a) ? 1 : 0;
          1: tk = (mx[rd] != a) ? 1 : 0;
          2: tk = (mx[rd] < a) ? 1 : 0;
          default: tk = (mx[rd] >= a) ? 1 : 0;
        endcase
      end
    endcase
    rdo = rd;
    pcv = mpc;
    simm = (imm >= 16) ? imm - 32 : imm;
    mpc = (tk != 0) ? (mpc + simm + 256) % 256 : (mpc + 1) % 256;
    if (wr != 0 && rd != 0) mx[rd] = d;
  endfunction

  task automatic issue(input logic [15:0] ins, input int hold, input string tag);
    int ed, er, ep, et, el, n;
    model(ins, ed, er, ep, et, el);
    @(negedge clk);
    chk({tag, "_instr_ready"}, 32'(instr_ready), 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    n = 1;
    while (!res_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, el);
    chk({tag, "_res_data"}, 32'(res_data), ed);
    chk({tag, "_res_rd"}, 32'(res_rd), er);
    chk({tag, "_res_pc"}, 32'(res_pc), ep);
    chk({tag, "_res_taken"}, 32'(res_taken), et);
    obs_data = int'(res_data); obs_pc = int'(res_pc); obs_taken = int'(res_taken);
    for (int k = 0; k < hold; k++) begin
      instr_valid = 1'b1;
      instr = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(res_valid), 1);
      chk({tag, "_hold_ready"}, 32'(instr_ready), 0);
      chk({tag, "_hold_data"}, 32'(res_data), ed);
      chk({tag, "_hold_pc"}, 32'(res_pc), ep);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      chk(tag, 32'(dbg_data), mx[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; res_ready = 1'b0; dbg_sel = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_res_pc", 32'(res_pc), 0);
    chk_regs("rst_regs");
    @(negedge clk);
    rst_n = 1'b1;

    issue(enc(2'b01, 3'd1, 3'd0, 5'd5, 3'b111), 0, "li_x1");
    chk("li_x1_const", obs_data, 5);
    dbg_sel = 3'd1; #1;
    chk("li_x1_dbg", 32'(dbg_data), 5);
    issue(enc(2'b01, 3'd2, 3'd0, 5'd7, 3'b111), 0, "li_x2");
    issue(enc(2'b00, 3'd3, 3'd1, 5'd2, 3'b001), 0, "sub");
    chk("sub_const", obs_data, 32'hFE);
    issue(enc(2'b00, 3'd4, 3'd1, 5'd2, 3'b111), 0, "slt");
    chk("slt_const", obs_data, 1);
    issue(enc(2'b00, 3'd5, 3'd2, 5'd1, 3'b101), 0, "sll");
    chk("sll_const", obs_data, 32'hE0);

    issue(enc(2'b10, 3'd1, 3'd0, 5'd3, 3'b001), 0, "store");
    issue(enc(2'b10, 3'd6, 3'd0, 5'd3, 3'b000), 1, "load_x6");
    dbg_sel = 3'd6; #1;
    chk("load_x6_dbg", 32'(dbg_data), 5);
    issue(enc(2'b10, 3'd7, 3'd1, 5'd14, 3'b000), 0, "load_wrap");
    chk("load_wrap_const", obs_data, 5);

    issue(enc(2'b10, 3'd0, 3'd0, 5'd0, 3'b010), 0, "nop");
    issue(enc(2'b10, 3'd0, 3'd0, 5'd0, 3'b010), 0, "nop");
    issue(enc(2'b11, 3'd1, 3'd1, 5'b11110, 3'b000), 0, "beq");
    chk("beq_pc_const", obs_pc, 10);
    chk("beq_taken_const", obs_taken, 1);
    issue(enc(2'b10, 3'd0, 3'd0, 5'd0, 3'b010), 0, "after_beq");
    chk("after_beq_pc_const", obs_pc, 8);
    issue(enc(2'b10, 3'd0, 3'd0, 5'd0, 3'b010), 0, "nop");
    issue(enc(2'b11, 3'd1, 3'd1, 5'b11110, 3'b001), 0, "bne");
    chk("bne_taken_const", obs_taken, 0);
    issue(enc(2'b00, 3'd0, 3'd1, 5'd2, 3'b000), 5, "add_x0_hold");
    chk("add_x0_pc_const", obs_pc, 11);
    chk("add_x0_data_const", obs_data, 12);
    chk_regs("dir_regs");

    for (int t = 0; t < 80; t++) begin
      issue(16'($urandom), int'($urandom_range(0, 3)), "rnd");
      if (t % 10 == 9) chk_regs("rnd_regs");
    end

    issue(enc(2'b01, 3'd5, 3'd0, 5'd9, 3'b111), 0, "li_x5");
    @(negedge clk);
    instr = enc(2'b10, 3'd5, 3'd0, 5'd3, 3'b000);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("mem_state_no_valid", 32'(res_valid), 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_instr_ready", 32'(instr_ready), 1);
    chk("arst_res_valid", 32'(res_valid), 0);
    chk("arst_res_data", 32'(res_data), 0);
    chk("arst_res_rd", 32'(res_rd), 0);
    chk("arst_res_pc", 32'(res_pc), 0);
    chk("arst_res_taken", 32'(res_taken), 0);
    chk_regs("arst_regs");
    @(negedge clk);
    rst_n = 1'b1;
    issue(enc(2'b10, 3'd6, 3'd0, 5'd3, 3'b000), 0, "post_rst_load");
    chk("post_rst_load_pc_const", obs_pc, 0);
    chk_regs("final_regs");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
